// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing controller.
// A Moore FSM walks each instruction through fetch/decode/execute/memory/
// writeback, drives every datapath enable and mux select, shares one memory
// port through mem_req/mem_ready, and counts retired instructions.
//
// Handshake: mem_req (with mem_we and adr_src) is held stable for as long as
// the FSM sits in an access state; the access completes on the rising edge
// where mem_req and mem_ready are both high, and only then does the FSM advance.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [2:0]  sel_ext,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic [31:0] instret_q;
    logic        retire;

    logic [6:0]  opcode;
    logic        funct3_lsb;
    logic        unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3_lsb        = instr[12];
    assign unused_instr_bits = ^{instr[31:13], instr[11:7]};

    // State, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Next-state, datapath controls and retire strobe for the current state.
    always_comb begin
        state_d    = S_FETCH;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                // Strobes are masked while reset is held so an abandoned
                // access never leaks a request or a PC/IR load.
                mem_req    = rst_n;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_we   = rst_n;
                    pc_we   = rst_n;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                retire  = mem_ready;
                state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                // funct3[0] inverts the sense of the zero flag (beq vs bne).
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_we     = zero ^ funct3_lsb;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we     = 1'b1;
                state_d   = S_ALUWB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate-format select, decoded from the opcode regardless of state.
    always_comb begin
        sel_ext = 3'b000;
        case (opcode)
            OP_STORE:  sel_ext = 3'b001;
            OP_BRANCH: sel_ext = 3'b010;
            OP_JAL:    sel_ext = 3'b011;
            OP_LUI:    sel_ext = 3'b100;
            default:   sel_ext = 3'b000;
        endcase
    end

    assign illegal = illegal_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction classes through
// the FSM and checks state sequence, strobes, selects and the retire counter.
module tb_multicycle_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  result_src;
    logic [2:0]  sel_ext;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    int total = 0;
    int bad   = 0;
    int ir_cnt = 0;
    int rf_cnt = 0;
    int pc_cnt = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0050A023;
    localparam logic [31:0] I_BEQ  = 32'h00000063;
    localparam logic [31:0] I_BNE  = 32'h00001063;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_LUI  = 32'h000002B7;
    localparam logic [31:0] I_ZERO = 32'h00000000;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .sel_ext    (sel_ext),
        .illegal    (illegal),
        .instret    (instret),
        .state      (state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, settle, check the state,
    // and tally the write strobes seen in that cycle.
    task automatic cy(input string tag, input logic rdy, input logic z, input logic [3:0] exp_state);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
        chk(tag, {28'd0, state}, {28'd0, exp_state});
        ir_cnt += int'(ir_we);
        rf_cnt += int'(rf_we);
        pc_cnt += int'(pc_we);
    endtask

    task automatic clr_cnt();
        ir_cnt = 0;
        rf_cnt = 0;
        pc_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        instr     = I_ADD;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_mem_req", {31'd0, mem_req}, 32'd1);

        // add x3,x1,x2 with zero-wait memory: 0,1,6,8,0
        clr_cnt();
        instr = I_ADD;
        cy("add_c1", 1'b1, 1'b0, 4'd0);
        chk("add_ir_we", {31'd0, ir_we}, 32'd1);
        chk("add_fetch_srcb", {30'd0, alu_src_b}, 32'd2);
        chk("add_fetch_res", {30'd0, result_src}, 32'd2);
        cy("add_c2", 1'b0, 1'b0, 4'd1);
        chk("add_dec_srca", {30'd0, alu_src_a}, 32'd1);
        chk("add_dec_req", {31'd0, mem_req}, 32'd0);
        cy("add_c3", 1'b0, 1'b0, 4'd6);
        chk("add_exec_op", {30'd0, alu_op}, 32'd2);
        chk("add_exec_srcb", {30'd0, alu_src_b}, 32'd0);
        chk("add_sel_ext", {29'd0, sel_ext}, 32'd0);
        cy("add_c4", 1'b0, 1'b0, 4'd8);
        chk("add_wb_rf_we", {31'd0, rf_we}, 32'd1);
        cy("add_c5", 1'b0, 1'b0, 4'd0);
        chk("add_rf_cnt", rf_cnt, 32'd1);
        chk("add_instret", instret, 32'd1);

        // lw with 2 fetch wait cycles and 1 read wait cycle: 8 cycles
        clr_cnt();
        instr = I_LW;
        chk("lw_c1_noir", {31'd0, ir_we}, 32'd0);
        cy("lw_c2", 1'b0, 1'b0, 4'd0);
        chk("lw_wait_req", {31'd0, mem_req}, 32'd1);
        chk("lw_wait_adr", {31'd0, adr_src}, 32'd0);
        cy("lw_c3", 1'b1, 1'b0, 4'd0);
        cy("lw_c4", 1'b0, 1'b0, 4'd1);
        cy("lw_c5", 1'b0, 1'b0, 4'd2);
        chk("lw_adr_srca", {30'd0, alu_src_a}, 32'd2);
        chk("lw_adr_srcb", {30'd0, alu_src_b}, 32'd1);
        cy("lw_c6", 1'b0, 1'b0, 4'd3);
        chk("lw_rd_req", {31'd0, mem_req}, 32'd1);
        chk("lw_rd_adr", {31'd0, adr_src}, 32'd1);
        chk("lw_rd_we", {31'd0, mem_we}, 32'd0);
        cy("lw_c7", 1'b1, 1'b0, 4'd3);
        cy("lw_c8", 1'b0, 1'b0, 4'd4);
        chk("lw_wb_rf", {31'd0, rf_we}, 32'd1);
        chk("lw_wb_res", {30'd0, result_src}, 32'd1);
        cy("lw_c9", 1'b0, 1'b0, 4'd0);
        chk("lw_ir_cnt", ir_cnt, 32'd1);
        chk("lw_instret", instret, 32'd2);

        // beq taken (zero=1)
        instr = I_BEQ;
        cy("beq1_c1", 1'b1, 1'b0, 4'd0);
        cy("beq1_c2", 1'b0, 1'b0, 4'd1);
        chk("beq_sel_ext", {29'd0, sel_ext}, 32'd2);
        cy("beq1_c3", 1'b0, 1'b1, 4'd9);
        chk("beq1_pc_we", {31'd0, pc_we}, 32'd1);
        chk("beq1_alu_op", {30'd0, alu_op}, 32'd1);
        // beq not taken (zero=0)
        cy("beq0_c1", 1'b1, 1'b0, 4'd0);
        chk("beq1_instret", instret, 32'd3);
        cy("beq0_c2", 1'b0, 1'b0, 4'd1);
        cy("beq0_c3", 1'b0, 1'b0, 4'd9);
        chk("beq0_pc_we", {31'd0, pc_we}, 32'd0);
        // bne with zero=0 is taken
        instr = I_BNE;
        cy("bne_c1", 1'b1, 1'b0, 4'd0);
        cy("bne_c2", 1'b0, 1'b0, 4'd1);
        cy("bne_c3", 1'b0, 1'b0, 4'd9);
        chk("bne_pc_we", {31'd0, pc_we}, 32'd1);

        // jal: 0,1,10,8
        instr = I_JAL;
        cy("jal_c1", 1'b1, 1'b0, 4'd0);
        chk("bne_instret", instret, 32'd5);
        cy("jal_c2", 1'b0, 1'b0, 4'd1);
        cy("jal_c3", 1'b0, 1'b0, 4'd10);
        chk("jal_pc_we", {31'd0, pc_we}, 32'd1);
        chk("jal_sel_ext", {29'd0, sel_ext}, 32'd3);
        chk("jal_srcb", {30'd0, alu_src_b}, 32'd2);
        cy("jal_c4", 1'b0, 1'b0, 4'd8);
        chk("jal_rf_we", {31'd0, rf_we}, 32'd1);

        // lui: 0,1,11,8
        instr = I_LUI;
        cy("lui_c1", 1'b1, 1'b0, 4'd0);
        chk("jal_instret", instret, 32'd6);
        cy("lui_c2", 1'b0, 1'b0, 4'd1);
        cy("lui_c3", 1'b0, 1'b0, 4'd11);
        chk("lui_srca", {30'd0, alu_src_a}, 32'd3);
        chk("lui_sel_ext", {29'd0, sel_ext}, 32'd4);
        cy("lui_c4", 1'b0, 1'b0, 4'd8);
        cy("lui_c5", 1'b0, 1'b0, 4'd0);
        chk("lui_instret", instret, 32'd7);

        // Reset pulsed during MEMREAD abandons the load.
        clr_cnt();
        instr = I_LW;
        cy("ra_c1", 1'b1, 1'b0, 4'd0);
        cy("ra_c2", 1'b0, 1'b0, 4'd1);
        cy("ra_c3", 1'b0, 1'b0, 4'd2);
        cy("ra_c4", 1'b0, 1'b0, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_async_state", {28'd0, state}, 32'd0);
        chk("ra_rf_we", {31'd0, rf_we}, 32'd0);
        chk("ra_pc_we", {31'd0, pc_we}, 32'd0);
        cy("ra_held", 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        #1;
        chk("ra_refetch_req", {31'd0, mem_req}, 32'd1);
        chk("ra_refetch_adr", {31'd0, adr_src}, 32'd0);
        chk("ra_instret", instret, 32'd0);
        cy("ra_c5", 1'b0, 1'b0, 4'd0);
        chk("ra_rf_cnt", rf_cnt, 32'd0);

        // instret wraps from all-ones on a retiring sw.
        instr = I_SW;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cy("sw_c1", 1'b1, 1'b0, 4'd0);
        chk("sw_pre_instret", instret, 32'hFFFF_FFFF);
        cy("sw_c2", 1'b0, 1'b0, 4'd1);
        cy("sw_c3", 1'b0, 1'b0, 4'd2);
        chk("sw_sel_ext", {29'd0, sel_ext}, 32'd1);
        cy("sw_c4", 1'b1, 1'b0, 4'd5);
        chk("sw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw_adr_src", {31'd0, adr_src}, 32'd1);
        cy("sw_c5", 1'b0, 1'b0, 4'd0);
        chk("sw_wrap_instret", instret, 32'd0);

        // Illegal opcode halts until reset.
        instr = I_ZERO;
        cy("ill_c1", 1'b1, 1'b0, 4'd0);
        cy("ill_c2", 1'b0, 1'b0, 4'd1);
        for (int i = 0; i < 10; i++) begin
            cy("ill_halt_state", 1'b1, 1'b0, 4'd15);
            chk("ill_flag", {31'd0, illegal}, 32'd1);
            chk("ill_mem_req", {31'd0, mem_req}, 32'd0);
            chk("ill_instret", instret, 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("ill_rst_flag", {31'd0, illegal}, 32'd0);
        chk("ill_rst_state", {28'd0, state}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ill_rel_req", {31'd0, mem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle RV32I datapath variant. It replaces the single-cycle decode path with a Moore-style state machine that spreads each instruction over fetch, decode, execute, memory and writeback cycles. One unified instruction/data memory port is shared through a req/ready handshake. The block drives every datapath enable and mux select, the ALU operation class for the existing ALU decoder, and the immediate-extension select, and keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12])
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- adr_src  out  1  address mux: 0=PC, 1=ALUOut
- ir_we  out  1  instruction register / OldPC load
- pc_we  out  1  PC load from result bus
- rf_we  out  1  register file write
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- alu_op  out  2  00=add, 01=sub, 10=decode funct3/funct7
- result_src  out  2  00=ALUOut, 01=read data, 10=ALU result
- sel_ext  out  3  immediate type: 000=I, 001=S, 010=B, 011=J, 100=U
- illegal  out  1  sticky illegal-opcode flag
- instret  out  32  retired instruction count
- state  out  4  current state (debug)

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, HALT=15. Unused encodings go to FETCH.
- Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0, srcA=00, srcB=10, alu_op=00, result_src=10. ir_we and pc_we are asserted only when mem_ready=1, and the state then moves to DECODE. Otherwise the state holds.
- DECODE: srcA=01, srcB=01, alu_op=00, computing the branch/jump target into ALUOut.
- DECODE dispatch on opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> HALT
- MEMADR: srcA=10, srcB=01, alu_op=00. Next state is MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, rf_we=1. Next state FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. Holds until mem_ready, then goes to FETCH.
- EXEC_R: srcA=10, srcB=00, alu_op=10. Next state ALUWB.
- EXEC_I: srcA=10, srcB=01, alu_op=10. Next state ALUWB.
- LUI: srcA=11, srcB=01, alu_op=00. Next state ALUWB.
- ALUWB: result_src=00, rf_we=1. Next state FETCH.
- BRANCH: srcA=10, srcB=00, alu_op=01, result_src=00. pc_we = zero XOR funct3[0] (beq/bne; other funct3 values follow the same rule). Next state FETCH.
- JAL: srcA=01, srcB=10, alu_op=00, result_src=00, pc_we=1. Next state ALUWB, which writes PC+4 to rd.
- sel_ext is decoded combinationally from the opcode in every state:
  - load/I-ALU -> 000
  - store -> 001
  - branch -> 010
  - jal -> 011
  - lui -> 100
  - otherwise -> 000
- HALT: all enables 0, illegal=1, absorbing until reset.
- instret increments by 1, wrapping modulo 2^32, on each terminal cycle:
  - MEMWB
  - ALUWB
  - BRANCH
  - MEMWRITE with mem_ready=1
- HALT never increments instret.

## Timing
- Reset (async assert, synchronous release on clk):
  - state=FETCH
  - instret=0
  - illegal=0
  - mem_req=1 immediately (FETCH outputs)
  - all other enables 0
- All outputs are combinational from state, except ir_we/pc_we in FETCH (gated by mem_ready) and pc_we in BRANCH (gated by zero, funct3[0]).
- Zero-wait latencies, FETCH through last state:
  - lw 5 cycles
  - sw 4 cycles
  - R/I/lui 4 cycles
  - jal 4 cycles
  - branch 3 cycles
- Each wait cycle of mem_ready adds one cycle. mem_req and the address select stay stable while waiting.
- Reset asserted mid-access drops mem_req only for the reset duration. The access is abandoned and no rf_we or pc_we is issued.

## Test plan
- Reset, then add x3,x1,x2 with mem_ready=1 -> states 0,1,6,8,0. rf_we high in cycle 4 only. instret=1.
- lw with 2 fetch wait cycles and 1 read wait cycle -> FETCH held 3 cycles, MEMREAD held 2. ir_we for exactly 1 cycle. Total 8 cycles. rf_we with result_src=01.
- beq, first with zero=1 and then with zero=0 -> pc_we=1 in the BRANCH cycle for zero=1 and 0 for zero=0. bne (funct3=001) with zero=0 -> pc_we=1.
- Instruction 0x00000000 -> DECODE goes to HALT. illegal=1, mem_req=0, instret frozen, held for 10 cycles. rst_n low clears illegal.
- rst_n pulsed low during MEMREAD -> state=0 asynchronously. No rf_we. Next fetch is issued with adr_src=0.
- Force instret to 0xFFFFFFFF, then retire one sw -> instret=0x00000000.
